// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed quadratic integrate-and-fire scheduler: one shared update datapath
// sweeps N_NEURONS membrane potentials per tick and emits spike events on valid/ready.
module qif_neuron_scheduler #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int          V_RESET   = -20,
    parameter int          V_TH      = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    output logic [IDX_W-1:0] cur_idx,
    input  logic [7:0]       cur_in,
    output logic             busy,
    output logic             sweep_done,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    input  logic             spike_ready,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_v,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int unsigned V_W = 8;
    localparam int unsigned S_W = 11;
    localparam logic signed [V_W-1:0] V_RST = V_W'(V_RESET);
    localparam logic signed [V_W-1:0] V_THS = V_W'(V_TH);
    localparam logic signed [S_W-1:0] S_MAX = S_W'(127);
    localparam logic signed [S_W-1:0] S_MIN = S_W'(-128);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       cur_idx_q;
    logic                   sweep_done_q;
    logic                   spike_valid_q;
    logic [IDX_W-1:0]       spike_idx_q;
    logic [V_W-1:0]         rd_v_q;
    logic                   overrun_q;
    logic signed [V_W-1:0]  vmem_q [N_NEURONS];

    logic signed [V_W-1:0]  v_k_c;
    logic signed [S_W-1:0]  v_ext_c;
    logic signed [S_W-1:0]  q_c;
    logic signed [S_W-1:0]  sq_c;
    logic signed [S_W-1:0]  i4_c;
    logic signed [S_W-1:0]  sum_c;
    logic signed [V_W-1:0]  v_upd_c;
    logic signed [V_W-1:0]  v_next_c;
    logic                   fire_c;
    logic                   stall_c;
    logic                   commit_c;
    logic                   last_c;

    // QIF update for the neuron under the sweep pointer; threshold is tested on the stored V
    always_comb begin
        v_k_c   = vmem_q[cur_idx_q];
        fire_c  = (v_k_c >= V_THS);
        v_ext_c = S_W'(v_k_c);
        q_c     = v_ext_c / S_W'(8);
        sq_c    = q_c * q_c;
        i4_c    = S_W'($signed(cur_in)) / S_W'(4);
        sum_c   = v_ext_c + sq_c + i4_c;
        v_upd_c = V_W'(sum_c);
        if (sum_c > S_MAX) begin
            v_upd_c = V_W'(S_MAX);
        end else if (sum_c < S_MIN) begin
            v_upd_c = V_W'(S_MIN);
        end
        v_next_c = fire_c ? V_RST : v_upd_c;
        stall_c  = fire_c && spike_valid_q && !spike_ready;
        commit_c = (state_q == RUN) && !stall_c;
        last_c   = (cur_idx_q == IDX_W'(N_NEURONS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cur_idx_q     <= '0;
            sweep_done_q  <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            rd_v_q        <= '0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                vmem_q[i] <= V_RST;
            end
        end else begin
            sweep_done_q <= 1'b0;
            rd_v_q       <= vmem_q[rd_idx];

            if (tick && (state_q == RUN)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            // a new spike replaces a handshaking one without a bubble
            if (commit_c && fire_c) begin
                spike_valid_q <= 1'b1;
                spike_idx_q   <= cur_idx_q;
            end else if (spike_valid_q && spike_ready) begin
                spike_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q   <= RUN;
                        cur_idx_q <= '0;
                    end
                end
                RUN: begin
                    if (commit_c) begin
                        vmem_q[cur_idx_q] <= v_next_c;
                        if (last_c) begin
                            state_q      <= IDLE;
                            sweep_done_q <= 1'b1;
                            cur_idx_q    <= '0;
                        end else begin
                            cur_idx_q <= cur_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cur_idx     = cur_idx_q;
    assign busy        = (state_q == RUN);
    assign sweep_done  = sweep_done_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign rd_v        = rd_v_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Scoreboard bench for qif_neuron_scheduler: stimulus pushes expected spikes and
// sweep_done cycles, a negedge monitor pops and compares; state is read via rd_v.
module tb_qif_neuron_scheduler;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tick = 1'b0;
    logic [W-1:0] cur_idx;
    logic [7:0]   cur_in;
    logic         busy;
    logic         sweep_done;
    logic         spike_valid;
    logic [W-1:0] spike_idx;
    logic         spike_ready = 1'b1;
    logic [W-1:0] rd_idx = '0;
    logic [7:0]   rd_v;
    logic         overrun;
    logic         overrun_clr = 1'b0;

    logic [7:0]   cur_tab [N];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           exp_spk [$];
    int           exp_done [$];

    qif_neuron_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .cur_idx     (cur_idx),
        .cur_in      (cur_in),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .spike_ready (spike_ready),
        .rd_idx      (rd_idx),
        .rd_v        (rd_v),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // requester's combinational current lookup
    assign cur_in = cur_tab[cur_idx];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: spike handshakes and sweep_done pulses against the scoreboard queues
    always @(negedge clk) begin
        if (!reset) begin
            if (spike_valid && spike_ready) begin
                if (exp_spk.size() == 0) chk("unexpected_spike", int'(spike_idx), -1);
                else chk("spike_idx", int'(spike_idx), exp_spk.pop_front());
            end
            if (sweep_done) begin
                if (exp_done.size() == 0) chk("unexpected_sweep_done", cyc, -1);
                else begin
                    int e;
                    e = exp_done.pop_front();
                    if (e >= 0) chk("sweep_done_cycle", cyc, e);
                end
            end
        end
    end

    task automatic set_cur(input int a, input int b, input int c, input int d);
        cur_tab[0] = 8'(a);
        cur_tab[1] = 8'(b);
        cur_tab[2] = 8'(c);
        cur_tab[3] = 8'(d);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_spike_valid", int'(spike_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_rd_v", int'(rd_v), 0);
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // now=1: raise tick in the current (sweep_done) cycle
    task automatic start_sweep(input bit now, input bit timed);
        if (!now) @(negedge clk);
        tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        exp_done.push_back(timed ? cyc + N : -1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sweep_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, int'(seen), 1);
    endtask

    task automatic read_v(input int idx, output int v);
        @(posedge clk); #1 rd_idx = W'(idx);
        @(posedge clk);
        @(negedge clk);
        v = int'($signed(rd_v));
    endtask

    task automatic chk_all(input string name, input int e0, input int e1, input int e2, input int e3);
        int v;
        int ev [N];
        ev = '{e0, e1, e2, e3};
        for (int i = 0; i < N; i++) begin
            read_v(i, v);
            chk($sformatf("%s_v%0d", name, i), v, ev[i]);
        end
    endtask

    // leaves the sweep stalled at neuron 2 with neuron 0's spike pending
    task automatic setup_stall(input bit timed);
        do_reset();
        set_cur(100, 0, 100, 0);
        spike_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            start_sweep(1'b0, 1'b1);
            wait_done("setup_done");
        end
        spike_ready = 1'b0;
        start_sweep(1'b0, timed);
        repeat (4) @(negedge clk);
        chk("stall_busy", int'(busy), 1);
        chk("stall_cur_idx", int'(cur_idx), 2);
        chk("stall_spike_valid", int'(spike_valid), 1);
        chk("stall_spike_idx", int'(spike_idx), 0);
    endtask

    initial begin
        int v;
        set_cur(0, 0, 0, 0);

        // zero current: -20 -> -16 -> -12 -> -11, back-to-back tick in sweep_done cycle
        do_reset();
        start_sweep(1'b0, 1'b1);
        wait_done("t1_done1");
        chk_all("t1_s1", -16, -16, -16, -16);
        start_sweep(1'b0, 1'b1);
        wait_done("t1_done2");
        start_sweep(1'b1, 1'b1);
        wait_done("t1_done3");
        chk_all("t1_s3", -11, -11, -11, -11);

        // neuron 1 driven to threshold: -20 -> 9 -> 35 -> 76, fires on the fourth sweep
        do_reset();
        set_cur(0, 100, 0, 0);
        for (int s = 0; s < 3; s++) begin
            start_sweep(1'b0, 1'b1);
            wait_done("t2_done");
        end
        read_v(1, v);
        chk("t2_v1_pre", v, 76);
        exp_spk.push_back(1);
        start_sweep(1'b0, 1'b1);
        wait_done("t2_done4");
        chk_all("t2_s4", -10, -20, -10, -10);

        // stall on back-to-back spikes, then one-cycle ready releases both
        setup_stall(1'b0);
        read_v(2, v);
        chk("t3_v2_held", v, 76);
        chk("t3_cur_idx_held", int'(cur_idx), 2);
        exp_spk.push_back(0);
        exp_spk.push_back(2);
        @(posedge clk); #1 spike_ready = 1'b1;
        @(posedge clk); #1 spike_ready = 1'b0;
        @(negedge clk);
        chk("t3_replaced_valid", int'(spike_valid), 1);
        chk("t3_replaced_idx", int'(spike_idx), 2);
        wait_done("t3_done");
        @(posedge clk); #1 spike_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_drained", int'(spike_valid), 0);
        chk_all("t3_end", -20, -10, -20, -10);

        // overrun: tick at e2 ignored, timing unchanged; clear; set wins over clear
        do_reset();
        set_cur(0, 0, 0, 0);
        start_sweep(1'b0, 1'b1);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        wait_done("t4_done1");
        chk("t4_idle_at_done", int'(busy), 0);
        @(negedge clk);
        chk("t4_no_restart", int'(busy), 0);
        chk("t4_overrun_set", int'(overrun), 1);
        @(posedge clk); #1 overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        @(negedge clk);
        chk("t4_overrun_clr", int'(overrun), 0);
        start_sweep(1'b0, 1'b1);
        tick = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b1;
        @(posedge clk); #1 tick = 1'b0; overrun_clr = 1'b0;
        wait_done("t4_done2");
        chk("t4_set_wins", int'(overrun), 1);

        // reset while stalled aborts the sweep
        setup_stall(1'b0);
        void'(exp_done.pop_back());
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", int'(busy), 0);
        chk("t5_spike_valid", int'(spike_valid), 0);
        spike_ready = 1'b1;
        chk_all("t5_rst", -20, -20, -20, -20);

        // negative current: -20 -> -48 -> -44, no spike
        set_cur(-128, -128, -128, -128);
        start_sweep(1'b0, 1'b1);
        wait_done("t6_done1");
        chk_all("t6_s1", -48, -48, -48, -48);
        start_sweep(1'b0, 1'b1);
        wait_done("t6_done2");
        chk_all("t6_s2", -44, -44, -44, -44);
        chk("t6_no_spike", int'(spike_valid), 0);

        repeat (3) @(negedge clk);
        chk("spike_queue_empty", exp_spk.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
